// File: rtl/key_voice_alloc_pkg.sv
// key_voice_alloc_pkg
// Shared definitions for the PS/2 key-to-voice allocator: parser state
// encoding, PS/2 set-2 control bytes, voice count and age width.
package key_voice_alloc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } parse_state_t;

    localparam logic [7:0] SC_F0 = 8'hF0;
    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_AA = 8'hAA;
    localparam logic [7:0] SC_FA = 8'hFA;
    localparam logic [7:0] SC_FE = 8'hFE;

    localparam int NUM_VOICES = 3;
    localparam int AGE_W      = 2;
    localparam int IDX_W      = 2;

    localparam logic [AGE_W-1:0] AGE_MAX = 2'd2;
    localparam logic [AGE_W-1:0] AGE_ONE = 2'd1;

    // Keyboard housekeeping bytes (BAT ok, ack, resend, errors) carry no key.
    function automatic logic is_ctrl_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == SC_AA) || (b == SC_FA) ||
               (b == SC_FE) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/key_voice_alloc_parser.sv
// ps2_seq_parser
// Turns the PS/2 set-2 byte stream into registered make/break strobes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   all_off         panic: forces the parser to IDLE, suppresses strobes
//   scan_valid      one-cycle strobe for a new byte
//   scan_code[7:0]  the byte
//   make_stb        one-cycle pulse: key pressed, code in 'code'
//   brk_stb         one-cycle pulse: key released, code in 'code'
//   code[7:0]       last byte sampled
module ps2_seq_parser
    import key_voice_alloc_pkg::*;
#(
    parameter int IGNORE_EXT = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       all_off,
    input  logic       scan_valid,
    input  logic [7:0] scan_code,
    output logic       make_stb,
    output logic       brk_stb,
    output logic [7:0] code
);

    parse_state_t state, state_nxt;
    logic         make_nxt, brk_nxt;

    always_comb begin
        state_nxt = state;
        make_nxt  = 1'b0;
        brk_nxt   = 1'b0;
        if (scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == SC_F0)
                        state_nxt = ST_BRK;
                    else if (scan_code == SC_E0)
                        state_nxt = ST_EXT;
                    else if (!is_ctrl_byte(scan_code))
                        make_nxt = 1'b1;
                end
                ST_BRK: begin
                    brk_nxt   = 1'b1;
                    state_nxt = ST_IDLE;
                end
                ST_EXT: begin
                    if (scan_code == SC_F0)
                        state_nxt = ST_EXT_BRK;
                    else begin
                        make_nxt  = (IGNORE_EXT == 0);
                        state_nxt = ST_IDLE;
                    end
                end
                ST_EXT_BRK: begin
                    brk_nxt   = (IGNORE_EXT == 0);
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
        // Panic drops any half-received sequence and any pending key event.
        if (all_off) begin
            state_nxt = ST_IDLE;
            make_nxt  = 1'b0;
            brk_nxt   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            make_stb <= 1'b0;
            brk_stb  <= 1'b0;
            code     <= 8'h00;
        end else begin
            state    <= state_nxt;
            make_stb <= make_nxt;
            brk_stb  <= brk_nxt;
            if (scan_valid)
                code <= scan_code;
        end
    end

endmodule

// File: rtl/key_voice_alloc.sv
// key_voice_alloc
// Assigns PS/2 key presses to three voice gates, with optional stealing of
// the oldest voice when all are busy.
// Ports:
//   iCLK, iRST                  clock, synchronous active-high reset
//   iSCAN_VALID, iSCAN_CODE     PS/2 byte strobe and byte
//   iALL_OFF                    panic level, releases all voices
//   keyN_on, keyN_code          per-voice gate and held make code
//   oSTEAL, oDROP               one-cycle pulses on steal / dropped key
module key_voice_alloc
    import key_voice_alloc_pkg::*;
#(
    parameter int STEAL_EN   = 1,
    parameter int IGNORE_EXT = 1
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSCAN_VALID,
    input  logic [7:0] iSCAN_CODE,
    input  logic       iALL_OFF,
    output logic       key1_on,
    output logic       key2_on,
    output logic       key3_on,
    output logic [7:0] key1_code,
    output logic [7:0] key2_code,
    output logic [7:0] key3_code,
    output logic       oSTEAL,
    output logic       oDROP
);

    logic       make_stb, brk_stb;
    logic [7:0] ev_code;

    ps2_seq_parser #(.IGNORE_EXT(IGNORE_EXT)) u_parser (
        .clk        (iCLK),
        .rst        (iRST),
        .all_off    (iALL_OFF),
        .scan_valid (iSCAN_VALID),
        .scan_code  (iSCAN_CODE),
        .make_stb   (make_stb),
        .brk_stb    (brk_stb),
        .code       (ev_code)
    );

    logic [NUM_VOICES-1:0]            gate, gate_n;
    logic [NUM_VOICES-1:0][7:0]       vcode, vcode_n;
    logic [NUM_VOICES-1:0][AGE_W-1:0] age, age_n;
    logic                             steal_n, drop_n;

    logic [NUM_VOICES-1:0] match;
    logic                  hit, any_free, alloc;
    logic [IDX_W-1:0]      free_idx, old_idx, tgt;
    logic [AGE_W-1:0]      old_age;

    // Voice selection: lowest free index; oldest active voice, ties to lowest.
    always_comb begin
        free_idx = '0;
        any_free = 1'b0;
        old_idx  = '0;
        old_age  = age[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            match[i] = gate[i] && (vcode[i] == ev_code);
            if (!gate[i]) begin
                free_idx = IDX_W'(i);
                any_free = 1'b1;
            end
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age[i] > old_age) begin
                old_age = age[i];
                old_idx = IDX_W'(i);
            end
        end
        hit = |match;
    end

    always_comb begin
        gate_n  = gate;
        vcode_n = vcode;
        age_n   = age;
        steal_n = 1'b0;
        drop_n  = 1'b0;
        alloc   = 1'b0;
        tgt     = free_idx;
        if (iALL_OFF) begin
            gate_n = '0;
        end else if (brk_stb) begin
            gate_n = gate & ~match;
        end else if (make_stb && !hit) begin
            if (any_free) begin
                alloc = 1'b1;
            end else if (STEAL_EN != 0) begin
                alloc   = 1'b1;
                tgt     = old_idx;
                steal_n = 1'b1;
            end else begin
                drop_n = 1'b1;
            end
        end
        if (alloc) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == tgt) begin
                    gate_n[i]  = 1'b1;
                    vcode_n[i] = ev_code;
                    age_n[i]   = '0;
                end else if (gate[i] && (age[i] != AGE_MAX)) begin
                    age_n[i] = age[i] + AGE_ONE;
                end
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            gate   <= '0;
            vcode  <= '0;
            age    <= '0;
            oSTEAL <= 1'b0;
            oDROP  <= 1'b0;
        end else begin
            gate   <= gate_n;
            vcode  <= vcode_n;
            age    <= age_n;
            oSTEAL <= steal_n;
            oDROP  <= drop_n;
        end
    end

    assign key1_on   = gate[0];
    assign key2_on   = gate[1];
    assign key3_on   = gate[2];
    assign key1_code = vcode[0];
    assign key2_code = vcode[1];
    assign key3_code = vcode[2];

endmodule

// File: tb/tb_key_voice_alloc.sv
// tb_key_voice_alloc
// Two allocators (stealing / dropping) share one directed byte stream.
// Each stimulus pushes the expected snapshot of both into a queue tagged
// with the cycle it must appear; a negedge monitor pops and compares.
module tb_key_voice_alloc;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scan_valid = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       all_off = 1'b0;

    logic       a1_on, a2_on, a3_on, a_steal, a_drop;
    logic [7:0] a1_c, a2_c, a3_c;
    logic       b1_on, b2_on, b3_on, b_steal, b_drop;
    logic [7:0] b1_c, b2_c, b3_c;

    always #5 clk = ~clk;

    key_voice_alloc #(.STEAL_EN(1), .IGNORE_EXT(1)) dut_a (
        .iCLK(clk), .iRST(rst), .iSCAN_VALID(scan_valid), .iSCAN_CODE(scan_code),
        .iALL_OFF(all_off),
        .key1_on(a1_on), .key2_on(a2_on), .key3_on(a3_on),
        .key1_code(a1_c), .key2_code(a2_c), .key3_code(a3_c),
        .oSTEAL(a_steal), .oDROP(a_drop)
    );

    key_voice_alloc #(.STEAL_EN(0), .IGNORE_EXT(1)) dut_b (
        .iCLK(clk), .iRST(rst), .iSCAN_VALID(scan_valid), .iSCAN_CODE(scan_code),
        .iALL_OFF(all_off),
        .key1_on(b1_on), .key2_on(b2_on), .key3_on(b3_on),
        .key1_code(b1_c), .key2_code(b2_c), .key3_code(b3_c),
        .oSTEAL(b_steal), .oDROP(b_drop)
    );

    // Snapshot layout: {on3,on2,on1, code1, code2, code3, steal, drop}
    typedef struct {
        int          cyc;
        string       tag;
        logic [28:0] a;
        logic [28:0] b;
    } item_t;

    item_t q[$];
    int    cyc = 0;
    int    n_chk = 0;
    int    n_fail = 0;
    bit    armed = 1'b0;

    wire [28:0] obs_a = {a3_on, a2_on, a1_on, a1_c, a2_c, a3_c, a_steal, a_drop};
    wire [28:0] obs_b = {b3_on, b2_on, b1_on, b1_c, b2_c, b3_c, b_steal, b_drop};

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [28:0] e(input logic [2:0] on, input logic [7:0] c1,
                                      input logic [7:0] c2, input logic [7:0] c3,
                                      input logic st = 1'b0, input logic dr = 1'b0);
        return {on, c1, c2, c3, st, dr};
    endfunction

    task automatic push(input int at, input string tag, input logic [28:0] ea,
                        input logic [28:0] eb);
        item_t it;
        it.cyc = at;
        it.tag = tag;
        it.a   = ea;
        it.b   = eb;
        q.push_back(it);
    endtask

    // Byte sampled on the next edge; outputs settle one edge later.
    task automatic send(input logic [7:0] b, input string tag,
                        input logic [28:0] ea, input logic [28:0] eb);
        @(negedge clk);
        scan_valid = 1'b1;
        scan_code  = b;
        push(cyc + 2, tag, ea, eb);
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        push(cyc + 1, tag, '0, '0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Panic together with a make byte: gates clear and the make never lands.
    task automatic panic_with_make(input logic [7:0] b, input logic [28:0] ea,
                                   input logic [28:0] eb);
        @(negedge clk);
        all_off    = 1'b1;
        scan_valid = 1'b1;
        scan_code  = b;
        push(cyc + 1, "all_off", ea, eb);
        push(cyc + 2, "all_off_blocks_make", ea, eb);
        @(negedge clk);
        all_off    = 1'b0;
        scan_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                item_t it;
                it = q.pop_front();
                n_chk += 2;
                if (it.cyc != cyc) begin
                    n_fail += 2;
                    $display("FAIL %s missed cycle %0d (now %0d)", it.tag, it.cyc, cyc);
                end else begin
                    if (obs_a !== it.a) begin
                        n_fail++;
                        $display("FAIL %s steal_dut got %h want %h", it.tag, obs_a, it.a);
                    end
                    if (obs_b !== it.b) begin
                        n_fail++;
                        $display("FAIL %s drop_dut got %h want %h", it.tag, obs_b, it.b);
                    end
                end
            end
        end else if (armed) begin
            // Between events the steal/drop pulses must be low.
            n_chk++;
            if ({a_steal, a_drop, b_steal, b_drop} !== 4'b0000) begin
                n_fail++;
                $display("FAIL idle_pulse cycle %0d got %b want 0000", cyc,
                         {a_steal, a_drop, b_steal, b_drop});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        do_reset("reset");
        armed = 1'b1;

        // Press and release one key.
        send(8'h1C, "make_1c",  e(3'b001, 8'h1C, 8'h00, 8'h00), e(3'b001, 8'h1C, 8'h00, 8'h00));
        send(8'hF0, "f0",       e(3'b001, 8'h1C, 8'h00, 8'h00), e(3'b001, 8'h1C, 8'h00, 8'h00));
        send(8'h1C, "break_1c", e(3'b000, 8'h1C, 8'h00, 8'h00), e(3'b000, 8'h1C, 8'h00, 8'h00));

        // Typematic repeat holds a single voice.
        for (int i = 0; i < 3; i++)
            send(8'h1C, "repeat_1c", e(3'b001, 8'h1C, 8'h00, 8'h00), e(3'b001, 8'h1C, 8'h00, 8'h00));
        send(8'hF0, "f0",       e(3'b001, 8'h1C, 8'h00, 8'h00), e(3'b001, 8'h1C, 8'h00, 8'h00));
        send(8'h1C, "break_1c", e(3'b000, 8'h1C, 8'h00, 8'h00), e(3'b000, 8'h1C, 8'h00, 8'h00));

        // Fill all voices, then overflow.
        send(8'h1C, "fill_1c", e(3'b001, 8'h1C, 8'h00, 8'h00), e(3'b001, 8'h1C, 8'h00, 8'h00));
        send(8'h1B, "fill_1b", e(3'b011, 8'h1C, 8'h1B, 8'h00), e(3'b011, 8'h1C, 8'h1B, 8'h00));
        send(8'h23, "fill_23", e(3'b111, 8'h1C, 8'h1B, 8'h23), e(3'b111, 8'h1C, 8'h1B, 8'h23));
        send(8'h2B, "over_2b", e(3'b111, 8'h2B, 8'h1B, 8'h23, 1'b1, 1'b0),
                               e(3'b111, 8'h1C, 8'h1B, 8'h23, 1'b0, 1'b1));
        send(8'h33, "over_33", e(3'b111, 8'h2B, 8'h33, 8'h23, 1'b1, 1'b0),
                               e(3'b111, 8'h1C, 8'h1B, 8'h23, 1'b0, 1'b1));

        // Release voice 3, unmatched break, refill the freed slot.
        send(8'hF0, "f0",       e(3'b111, 8'h2B, 8'h33, 8'h23), e(3'b111, 8'h1C, 8'h1B, 8'h23));
        send(8'h23, "break_23", e(3'b011, 8'h2B, 8'h33, 8'h23), e(3'b011, 8'h1C, 8'h1B, 8'h23));
        send(8'hF0, "f0",       e(3'b011, 8'h2B, 8'h33, 8'h23), e(3'b011, 8'h1C, 8'h1B, 8'h23));
        send(8'h77, "break_nomatch", e(3'b011, 8'h2B, 8'h33, 8'h23), e(3'b011, 8'h1C, 8'h1B, 8'h23));
        send(8'h4B, "make_4b",  e(3'b111, 8'h2B, 8'h33, 8'h4B), e(3'b111, 8'h1C, 8'h1B, 8'h4B));
        // 33 is held in the stealing unit only; the other must drop it.
        send(8'h33, "make_33",  e(3'b111, 8'h2B, 8'h33, 8'h4B),
                                e(3'b111, 8'h1C, 8'h1B, 8'h4B, 1'b0, 1'b1));

        // Panic mid-break sequence; parser must return to IDLE.
        send(8'hF0, "f0",       e(3'b111, 8'h2B, 8'h33, 8'h4B), e(3'b111, 8'h1C, 8'h1B, 8'h4B));
        panic_with_make(8'h5A,  e(3'b000, 8'h2B, 8'h33, 8'h4B), e(3'b000, 8'h1C, 8'h1B, 8'h4B));
        send(8'h1C, "after_panic", e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));

        // Extended and housekeeping bytes are discarded.
        send(8'hE0, "ext_e0",   e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'h75, "ext_make", e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'hE0, "ext_e0",   e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'hF0, "ext_f0",   e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'h75, "ext_break", e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'hAA, "ctrl_aa",  e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'hFA, "ctrl_fa",  e(3'b001, 8'h1C, 8'h33, 8'h4B), e(3'b001, 8'h1C, 8'h1B, 8'h4B));
        send(8'h1B, "after_ext", e(3'b011, 8'h1C, 8'h1B, 8'h4B), e(3'b011, 8'h1C, 8'h1B, 8'h4B));

        // Reset mid-break sequence; next key is a make.
        send(8'hF0, "f0",       e(3'b011, 8'h1C, 8'h1B, 8'h4B), e(3'b011, 8'h1C, 8'h1B, 8'h4B));
        do_reset("reset_in_brk");
        send(8'h1C, "after_reset", e(3'b001, 8'h1C, 8'h00, 8'h00), e(3'b001, 8'h1C, 8'h00, 8'h00));

        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain %0d entries left want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
